// File: rtl/vlc_bit_packer_pkg.sv
// Shared VLC definitions: accumulator geometry, packer state and code helpers.
package vlc_bit_packer_pkg;

  localparam int unsigned MAX_CODE_BITS = 64;
  localparam int unsigned ACC_WIDTH     = 128;

  typedef enum logic {StRun, StFlushTail} state_e;

  // Keep only the low n bits of a right-aligned code; n >= 64 keeps everything.
  function automatic logic [63:0] mask_code(input logic [63:0] v, input logic [6:0] n);
    logic [63:0] m;
    if (n >= 7'd64) m = '1;
    else            m = (64'd1 << n) - 64'd1;
    return v & m;
  endfunction

  // Bytes needed to hold a bit count of 0..64.
  function automatic logic [3:0] ceil_bytes(input logic [7:0] bits);
    logic [7:0] b;
    b = (bits + 8'd7) >> 3;
    return b[3:0];
  endfunction

endpackage

// File: rtl/vlc_bit_align.sv
// Masks a right-aligned code and places it MSB-first just below the current fill
// level of the 128-bit accumulator.
module vlc_bit_align
  import vlc_bit_packer_pkg::*;
(
  input  logic [63:0]          val,
  input  logic [6:0]           size,
  input  logic [7:0]           fill,
  output logic [ACC_WIDTH-1:0] placed
);

  logic [63:0]          mval;
  logic [ACC_WIDTH-1:0] top;

  // Left-justify the code at bit 127, then slide it down past the filled bits.
  always_comb begin
    mval   = mask_code(val, size);
    top    = {mval, 64'd0} << (7'd64 - size);
    placed = top >> fill;
  end

endmodule

// File: rtl/vlc_bit_packer.sv
// Packs variable-length codes into a contiguous MSB-first bitstream of 64-bit
// words. Never stalls; a flush pads the tail to a byte boundary and marks it last.
module vlc_bit_packer
  import vlc_bit_packer_pkg::*;
#(
  parameter int unsigned BITCNT_WIDTH = 32
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic [63:0]             val,
  input  logic [63:0]             size_of_bit,
  input  logic                    flush_bit,
  output logic                    out_valid,
  output logic [63:0]             out_data,
  output logic [3:0]              out_bytes,
  output logic                    out_last,
  output logic [BITCNT_WIDTH-1:0] slice_bits,
  output logic                    size_error
);

  state_e                  state_q, state_d;
  logic [ACC_WIDTH-1:0]    acc_q, acc_d, acc_sum, placed;
  logic [7:0]              fill_q, fill_d, nf;
  logic [BITCNT_WIDTH-1:0] bitcnt_q, bitcnt_d, bitcnt_sum;
  logic                    size_ok, take;
  logic [6:0]              add_size;

  logic                    err_d, valid_d, last_d;
  logic [63:0]             data_d;
  logic [3:0]              bytes_d;
  logic [BITCNT_WIDTH-1:0] slice_d;

  // Codes are only accepted in RUN; oversize codes and anything in the tail cycle are dropped.
  assign size_ok    = (size_of_bit <= 64'(MAX_CODE_BITS));
  assign take       = enable && size_ok && (state_q == StRun);
  assign add_size   = take ? size_of_bit[6:0] : 7'd0;
  assign acc_sum    = acc_q | placed;
  assign nf         = fill_q + {1'b0, add_size};
  assign bitcnt_sum = bitcnt_q + BITCNT_WIDTH'(add_size);

  vlc_bit_align u_align (
    .val    (val),
    .size   (add_size),
    .fill   (fill_q),
    .placed (placed)
  );

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StRun;
      acc_q    <= '0;
      fill_q   <= '0;
      bitcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      fill_q   <= fill_d;
      bitcnt_q <= bitcnt_d;
    end
  end

  // Next state: append the code, retire a full word, or set up the flush tail.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    fill_d   = fill_q;
    bitcnt_d = bitcnt_q;
    err_d    = size_error;
    unique case (state_q)
      StRun: begin
        if (enable && !size_ok) err_d = 1'b1;
        if (flush_bit) begin
          if (nf <= 8'd64) begin
            acc_d    = '0;
            fill_d   = '0;
            bitcnt_d = '0;
          end else begin
            acc_d    = acc_sum << 64;
            fill_d   = nf - 8'd64;
            bitcnt_d = bitcnt_sum;
            state_d  = StFlushTail;
          end
        end else if (nf >= 8'd64) begin
          acc_d    = acc_sum << 64;
          fill_d   = nf - 8'd64;
          bitcnt_d = bitcnt_sum;
        end else begin
          acc_d    = acc_sum;
          fill_d   = nf;
          bitcnt_d = bitcnt_sum;
        end
      end
      StFlushTail: begin
        if (enable || flush_bit) err_d = 1'b1;
        acc_d    = '0;
        fill_d   = '0;
        bitcnt_d = '0;
        state_d  = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  // Output decode for the word to be presented after this edge.
  always_comb begin
    valid_d = 1'b0;
    last_d  = 1'b0;
    data_d  = '0;
    bytes_d = '0;
    slice_d = slice_bits;
    unique case (state_q)
      StRun: begin
        if (flush_bit) begin
          valid_d = 1'b1;
          data_d  = acc_sum[127:64];
          if (nf <= 8'd64) begin
            last_d  = 1'b1;
            bytes_d = ceil_bytes(nf);
            slice_d = bitcnt_sum;
          end else begin
            bytes_d = 4'd8;
          end
        end else if (nf >= 8'd64) begin
          valid_d = 1'b1;
          data_d  = acc_sum[127:64];
          bytes_d = 4'd8;
        end
      end
      StFlushTail: begin
        valid_d = 1'b1;
        last_d  = 1'b1;
        data_d  = acc_q[127:64];
        bytes_d = ceil_bytes(fill_q);
        slice_d = bitcnt_q;
      end
      default: valid_d = 1'b0;
    endcase
  end

  // Registered outputs; size_error is sticky until reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_bytes  <= '0;
      out_last   <= 1'b0;
      slice_bits <= '0;
      size_error <= 1'b0;
    end else begin
      out_valid  <= valid_d;
      out_data   <= data_d;
      out_bytes  <= bytes_d;
      out_last   <= last_d;
      slice_bits <= slice_d;
      size_error <= err_d;
    end
  end

endmodule

// File: tb/tb_vlc_bit_packer.sv
// Self-checking bench for vlc_bit_packer: a bit-queue model of the stream,
// directed literal checks and randomized traffic.
module tb_vlc_bit_packer;

  logic        clock;
  logic        reset_n;
  logic        enable;
  logic [63:0] val;
  logic [63:0] size_of_bit;
  logic        flush_bit;
  logic        out_valid;
  logic [63:0] out_data;
  logic [3:0]  out_bytes;
  logic        out_last;
  logic [31:0] slice_bits;
  logic        size_error;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 0;

  // Model state: the pending bitstream as a queue, one entry per bit.
  bit          bq[$];
  logic [31:0] m_cnt   = 0;
  bit          m_tail  = 0;
  logic        e_valid = 0;
  logic [63:0] e_data  = 0;
  logic [3:0]  e_bytes = 0;
  logic        e_last  = 0;
  logic [31:0] e_slice = 0;
  logic        e_err   = 0;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  vlc_bit_packer #(.BITCNT_WIDTH(32)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .enable      (enable),
    .val         (val),
    .size_of_bit (size_of_bit),
    .flush_bit   (flush_bit),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_bytes   (out_bytes),
    .out_last    (out_last),
    .slice_bits  (slice_bits),
    .size_error  (size_error)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic emit_word();
    e_valid = 1'b1;
    e_bytes = 4'd8;
    e_data  = '0;
    for (int i = 63; i >= 0; i--) e_data[i] = bq.pop_front();
  endtask

  task automatic emit_last();
    int n;
    n       = bq.size();
    e_valid = 1'b1;
    e_last  = 1'b1;
    e_bytes = 4'((n + 7) / 8);
    e_data  = '0;
    for (int i = 0; i < n; i++) e_data[63-i] = bq[i];
    e_slice = m_cnt;
    m_cnt   = 0;
    bq.delete();
  endtask

  // Reference model: one step per clock edge, reset asynchronously.
  initial begin
    forever begin
      @(posedge clock or negedge reset_n);
      if (!reset_n) begin
        bq.delete();
        m_cnt = 0; m_tail = 0;
        e_valid = 0; e_data = 0; e_bytes = 0; e_last = 0; e_slice = 0; e_err = 0;
      end else begin
        e_valid = 0; e_data = 0; e_bytes = 0; e_last = 0;
        if (m_tail) begin
          if (enable || flush_bit) e_err = 1'b1;
          emit_last();
          m_tail = 0;
        end else begin
          if (enable) begin
            if (size_of_bit > 64) begin
              e_err = 1'b1;
            end else begin
              for (int i = int'(size_of_bit) - 1; i >= 0; i--) bq.push_back(val[i]);
              m_cnt = m_cnt + 32'(size_of_bit);
            end
          end
          if (flush_bit) begin
            if (bq.size() > 64) begin
              emit_word();
              m_tail = 1;
            end else begin
              emit_last();
            end
          end else if (bq.size() >= 64) begin
            emit_word();
          end
        end
      end
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clock);
      if (cmp_en) begin
        check("cmp_valid", 64'(out_valid), 64'(e_valid));
        check("cmp_data", out_data, e_data);
        check("cmp_bytes", 64'(out_bytes), 64'(e_bytes));
        check("cmp_last", 64'(out_last), 64'(e_last));
        check("cmp_slice", 64'(slice_bits), 64'(e_slice));
        check("cmp_err", 64'(size_error), 64'(e_err));
      end
    end
  end

  // One cycle: apply inputs, let the edge sample them, return 1 time unit after.
  task automatic drive(input logic en, input logic [63:0] v, input logic [63:0] sz,
                       input logic fl);
    enable = en; val = v; size_of_bit = sz; flush_bit = fl;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    enable = 0; val = 0; size_of_bit = 0; flush_bit = 0;
    reset_n = 1'b0;
    #1;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_slice", 64'(slice_bits), 64'd0);
    check("rst_err", 64'(size_error), 64'd0);
    check("rst_data", out_data, 64'd0);
    @(posedge clock);
    @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    enable = 0; val = 0; size_of_bit = 0; flush_bit = 0;
    @(posedge clock);
    #1;
    cmp_en = 1;
    do_reset();

    // Sixteen 4-bit codes of 0xF fill exactly one word, one cycle after the last code.
    for (int i = 0; i < 16; i++) begin
      drive(1, 64'hF, 64'd4, 0);
      if (i < 15) check("f16_early", 64'(out_valid), 64'd0);
    end
    check("f16_valid", 64'(out_valid), 64'd1);
    check("f16_data", out_data, ONES);
    check("f16_bytes", 64'(out_bytes), 64'd8);
    check("f16_last", 64'(out_last), 64'd0);

    // Empty-buffer flush closes the slice of 64 bits.
    drive(0, 0, 0, 1);
    check("empty_valid", 64'(out_valid), 64'd1);
    check("empty_last", 64'(out_last), 64'd1);
    check("empty_bytes", 64'(out_bytes), 64'd0);
    check("empty_data", out_data, 64'd0);
    check("empty_slice", 64'(slice_bits), 64'd64);

    // 3-bit code 101 then flush.
    drive(1, 64'h5, 64'd3, 0);
    drive(0, 0, 0, 1);
    check("c3_data", out_data, 64'hA000_0000_0000_0000);
    check("c3_bytes", 64'(out_bytes), 64'd1);
    check("c3_last", 64'(out_last), 64'd1);
    check("c3_slice", 64'(slice_bits), 64'd3);

    // 60 + 40 ones with flush on the second code: full word then a 36-bit tail.
    drive(1, ONES, 64'd60, 0);
    drive(1, ONES, 64'd40, 1);
    check("t100_word", out_data, ONES);
    check("t100_wlast", 64'(out_last), 64'd0);
    drive(0, 0, 0, 0);
    check("t100_tail", out_data, 64'hFFFF_FFFF_F000_0000);
    check("t100_bytes", 64'(out_bytes), 64'd5);
    check("t100_last", 64'(out_last), 64'd1);
    check("t100_slice", 64'(slice_bits), 64'd100);

    // Size 1 keeps only bit 0 of an all-ones value.
    drive(1, ONES, 64'd1, 0);
    drive(0, 0, 0, 1);
    check("mask_data", out_data, 64'h8000_0000_0000_0000);
    check("mask_slice", 64'(slice_bits), 64'd1);

    // Reset mid-stream discards buffered ones.
    for (int i = 0; i < 5; i++) drive(1, 64'h7, 64'd3, 0);
    do_reset();
    for (int i = 0; i < 16; i++) drive(1, 64'hA, 64'd4, 0);
    check("postrst_valid", 64'(out_valid), 64'd1);
    check("postrst_data", out_data, 64'hAAAA_AAAA_AAAA_AAAA);

    // Oversize code: dropped, error sticky.
    drive(1, ONES, 64'd65, 0);
    check("big_err", 64'(size_error), 64'd1);
    check("big_valid", 64'(out_valid), 64'd0);
    drive(0, 0, 0, 1);
    check("big_slice", 64'(slice_bits), 64'd64);
    check("big_sticky", 64'(size_error), 64'd1);

    // Input during the flush tail is dropped and flags an error.
    do_reset();
    drive(1, ONES, 64'd60, 0);
    drive(1, ONES, 64'd40, 1);
    drive(1, 64'h3, 64'd2, 0);
    check("tail_err", 64'(size_error), 64'd1);
    check("tail_data", out_data, 64'hFFFF_FFFF_F000_0000);
    check("tail_slice", 64'(slice_bits), 64'd100);
    drive(0, 0, 0, 0);

    // Randomized traffic, with one reset partway through.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic        en, fl;
      logic [63:0] sz, v;
      int          r;
      if (i == 1500) do_reset();
      r  = $urandom_range(0, 199);
      en = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 24) == 0);
      v  = {$urandom, $urandom};
      if (r == 0)      sz = 64'(65 + $urandom_range(0, 200));
      else if (r == 1) sz = 64'hFFFF_0000_0000_0000;
      else if (r < 30) sz = 64'd64;
      else             sz = 64'($urandom_range(0, 64));
      drive(en, v, sz, fl);
      if (fl) drive(0, 0, 0, 0);
    end
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vlc_bit_packer.md
Name: vlc_bit_packer

Overview:
- Consumes the variable-length code stream produced by the VLC output stage (val, size_of_bit, output_enable, flush_bit).
- Concatenates codes MSB-first into a contiguous bitstream and emits 64-bit words to the slice writer.
- On flush, zero-pads the tail to a byte boundary and marks the final word with its valid byte count.
- Never stalls: the upstream VLC stage has no backpressure, so the packer absorbs one code per cycle indefinitely.

Parameters:
- MAX_CODE_BITS, 64, largest legal size_of_bit; larger sizes are errors.
- BITCNT_WIDTH, 32, width of the per-slice bit counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset (0 reset, 1 not reset).
- enable  in  1  code valid this cycle (driven by the upstream output_enable).
- val  in  64  code bits, right-aligned; bits at or above size_of_bit are ignored.
- size_of_bit  in  64  code length in bits, 0..MAX_CODE_BITS.
- flush_bit  in  1  end of slice: pad and drain.
- out_valid  out  1  out_data is valid this cycle.
- out_data  out  64  packed bits, MSB first; the first stream bit is bit 63.
- out_bytes  out  4  valid bytes in out_data: 8 for full words, 0..8 on the last word.
- out_last  out  1  final word of the slice.
- slice_bits  out  BITCNT_WIDTH  unpadded bit count of the slice; updated on the out_last cycle and held.
- size_error  out  1  sticky: size_of_bit > MAX_CODE_BITS, or input arrived during FLUSH_TAIL.

Behaviour:
- Reset (asynchronous, reset_n low) clears all outputs, acc, fill and the bit counter, and sets state to RUN. Reset mid-slice discards all buffered bits with no output.
- Internal state:
  - acc[127:0], MSB-aligned.
  - fill[7:0]; fill < 64 at every cycle boundary in RUN.
  - bitcnt.
  - state ∈ {RUN, FLUSH_TAIL}.
- Masking: mval = val & ((1<<size)-1); size 64 passes all bits.
- RUN, enable=1 with size ≤ 64:
  - acc |= mval << (128 − fill − size).
  - nf = fill + size; bitcnt += size.
- Word emission: if nf ≥ 64, on the next edge out_valid=1, out_data=acc[127:64], out_bytes=8; then acc <<= 64 and fill = nf − 64.
- Latency: a completed word appears one clock after the code that completed it.
- Size 0: no-op, no output.
- Size > 64: the code is dropped, size_error set, state unchanged.
- flush_bit=1 (the same-cycle code, if any, is appended first). Let t = total buffered bits.
  - t ≤ 64: next cycle out_valid=1, out_last=1, out_data=acc[127:64] (pad bits zero), out_bytes=ceil(t/8), slice_bits=bitcnt; then acc, fill and bitcnt cleared.
  - t = 0: emits out_valid=1, out_last=1, out_bytes=0, out_data=0.
  - t > 64: next cycle emit a full word (out_bytes=8, out_last=0) and go to FLUSH_TAIL. The following cycle emit the remainder as the last word, then return to RUN.
- FLUSH_TAIL: enable or flush_bit asserted here is dropped and sets size_error. Upstream guarantees a one-cycle gap after flush.
- Outputs are registered. out_valid, out_last and out_bytes are 0 on cycles with no emission. out_data is 0 when not valid.
- bitcnt wraps modulo 2^BITCNT_WIDTH.
- size_error clears only on reset.

Decomposition:
- Shared vlc package holds:
  - MAX_CODE_BITS, the ACC_WIDTH=128 constant and the state enum {RUN, FLUSH_TAIL}.
  - A function for mask generation and a function for ceil-to-bytes, both shared with the VLC stages.
- One natural sub-module, vlc_bit_align: the combinational mask-and-shift of mval into the 128-bit accumulator position given fill and size.
- State machine, counters and output registers stay in vlc_bit_packer.

Test Plan:
- Reset mid-stream: feed 3-bit codes, assert reset_n=0 -> all outputs 0 immediately; after release, the first word contains only post-reset bits.
- Sixteen codes of val=0xF, size=4 -> one word 0xFFFF_FFFF_FFFF_FFFF with out_bytes=8, exactly one cycle after the 16th code.
- Code val=0x5, size=3, then flush -> out_data=0xA000_0000_0000_0000, out_bytes=1, out_last=1, slice_bits=3.
- Codes of size 60 and size 40 (all ones), then flush (t=100) -> a full word of ones; next cycle the last word 0xFFFF_FFFF_F000_0000 with out_bytes=5, slice_bits=100.
- val=0xFFFF_FFFF_FFFF_FFFF, size=1 -> only a single 1 bit is packed (mask check); a size=65 code -> dropped and size_error=1.
- Flush with an empty buffer -> out_valid=1, out_last=1, out_bytes=0; enable during FLUSH_TAIL -> input dropped, size_error=1.
